// File: rtl/pcc_stream_classifier.sv
// Popcount-compare classifier: accumulates pos/neg feature popcounts over BEATS beats
// and holds one registered decision (pos_total + BIAS >= neg_total) until accepted.
module pcc_stream_classifier #(
  parameter int POS_W  = 8,
  parameter int NEG_W  = 8,
  parameter int BEATS  = 4,
  parameter int BIAS   = 0,
  parameter int PCNT_W = $clog2(POS_W*BEATS+1),
  parameter int NCNT_W = $clog2(NEG_W*BEATS+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [POS_W-1:0]  pos,
  input  logic [NEG_W-1:0]  neg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              outval,
  output logic [PCNT_W-1:0] pos_cnt,
  output logic [NCNT_W-1:0] neg_cnt
);

  localparam int IDX_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BIAS_ABS = (BIAS < 0) ? -BIAS : BIAS;
  localparam int MAX_W    = (PCNT_W > NCNT_W) ? PCNT_W : NCNT_W;
  localparam int CMP_W    = MAX_W + $clog2(BIAS_ABS + 1) + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [PCNT_W-1:0]   pacc_q, pacc_d;
  logic [NCNT_W-1:0]   nacc_q, nacc_d;
  logic                outval_q, outval_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic [NCNT_W-1:0]   ncnt_q, ncnt_d;
  logic [PCNT_W-1:0]   psum;
  logic [NCNT_W-1:0]   nsum;

  function automatic logic [PCNT_W-1:0] popcnt_pos(input logic [POS_W-1:0] v);
    logic [PCNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < POS_W; i++) c = c + PCNT_W'(v[i]);
    return c;
  endfunction

  function automatic logic [NCNT_W-1:0] popcnt_neg(input logic [NEG_W-1:0] v);
    logic [NCNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NEG_W; i++) c = c + NCNT_W'(v[i]);
    return c;
  endfunction

  // Both totals are zero-extended into a signed field wide enough to absorb BIAS.
  function automatic logic decide(input logic [PCNT_W-1:0] p, input logic [NCNT_W-1:0] n);
    logic signed [CMP_W-1:0] ps, ns, bs;
    ps = signed'(CMP_W'(p));
    ns = signed'(CMP_W'(n));
    bs = CMP_W'(BIAS);
    return (ps + bs) >= ns;
  endfunction

  assign psum = pacc_q + popcnt_pos(pos);
  assign nsum = nacc_q + popcnt_neg(neg);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pacc_d   = pacc_q;
    nacc_d   = nacc_q;
    outval_d = outval_q;
    pcnt_d   = pcnt_q;
    ncnt_d   = ncnt_q;
    if (clear) begin
      state_d = ACCUM;
      idx_d   = '0;
      pacc_d  = '0;
      nacc_d  = '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            if (idx_q == LAST_IDX) begin
              pcnt_d   = psum;
              ncnt_d   = nsum;
              outval_d = decide(psum, nsum);
              pacc_d   = '0;
              nacc_d   = '0;
              idx_d    = '0;
              state_d  = HOLD;
            end else begin
              pacc_d = psum;
              nacc_d = nsum;
              idx_d  = idx_q + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) state_d = ACCUM;
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ACCUM;
      idx_q    <= '0;
      pacc_q   <= '0;
      nacc_q   <= '0;
      outval_q <= 1'b0;
      pcnt_q   <= '0;
      ncnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pacc_q   <= pacc_d;
      nacc_q   <= nacc_d;
      outval_q <= outval_d;
      pcnt_q   <= pcnt_d;
      ncnt_q   <= ncnt_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign outval    = outval_q;
  assign pos_cnt   = pcnt_q;
  assign neg_cnt   = ncnt_q;

endmodule

// File: tb/tb_pcc_stream_classifier.sv
// Bench for pcc_stream_classifier: truth table on a 1/2/1 instance, directed corner
// sequences on default and BIAS=3 instances, then random streaming vs a queue model.
module tb_pcc_stream_classifier;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] pos = '0;
  logic [7:0] neg = '0;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, outval;
  logic [5:0] pos_cnt, neg_cnt;
  logic       b_in_ready, b_out_valid, b_outval;
  logic [5:0] b_pos_cnt, b_neg_cnt;

  logic       t_valid = 1'b0;
  logic       t_pos = 1'b0;
  logic [1:0] t_neg = '0;
  logic       t_ready = 1'b0;
  logic       t_in_ready, t_out_valid, t_outval;
  logic       t_pos_cnt;
  logic [1:0] t_neg_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pcc_stream_classifier u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .pos(pos), .neg(neg), .out_valid(out_valid), .out_ready(out_ready), .outval(outval),
    .pos_cnt(pos_cnt), .neg_cnt(neg_cnt));

  pcc_stream_classifier #(.BIAS(3)) u_bias (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(b_in_ready),
    .pos(pos), .neg(neg), .out_valid(b_out_valid), .out_ready(out_ready), .outval(b_outval),
    .pos_cnt(b_pos_cnt), .neg_cnt(b_neg_cnt));

  pcc_stream_classifier #(.POS_W(1), .NEG_W(2), .BEATS(1), .BIAS(0)) u_tiny (
    .clk(clk), .rst_n(rst_n), .clear(1'b0), .in_valid(t_valid), .in_ready(t_in_ready),
    .pos(t_pos), .neg(t_neg), .out_valid(t_out_valid), .out_ready(t_ready), .outval(t_outval),
    .pos_cnt(t_pos_cnt), .neg_cnt(t_neg_cnt));

  typedef struct {
    logic       p;
    logic [1:0] n;
    logic       o;
    int         pc;
    int         nc;
  } vec_t;

  typedef struct {
    int p;
    int n;
    bit o;
    bit ob;
  } dec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge with the block in ACCUM; presents one beat for one cycle.
  task automatic send_beat(input logic [7:0] p, input logic [7:0] n);
    in_valid = 1'b1;
    pos = p;
    neg = n;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic release_decision();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  vec_t tbl[8];
  dec_t exp_q[$];
  dec_t d;

  initial begin
    int m_pacc, m_nacc, m_beats, done, cyc;
    tbl[0] = '{1'b0, 2'd0, 1'b1, 0, 0};
    tbl[1] = '{1'b0, 2'd1, 1'b0, 0, 1};
    tbl[2] = '{1'b0, 2'd2, 1'b0, 0, 1};
    tbl[3] = '{1'b0, 2'd3, 1'b0, 0, 2};
    tbl[4] = '{1'b1, 2'd0, 1'b1, 1, 0};
    tbl[5] = '{1'b1, 2'd1, 1'b1, 1, 1};
    tbl[6] = '{1'b1, 2'd2, 1'b1, 1, 1};
    tbl[7] = '{1'b1, 2'd3, 1'b0, 1, 2};

    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outval", outval, 0);
    chk("rst_pos_cnt", pos_cnt, 0);
    chk("rst_neg_cnt", neg_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      t_pos = tbl[i].p;
      t_neg = tbl[i].n;
      t_valid = 1'b1;
      @(negedge clk);
      t_valid = 1'b0;
      chk("tt_out_valid", t_out_valid, 1);
      chk("tt_in_ready", t_in_ready, 0);
      chk("tt_outval", t_outval, tbl[i].o);
      chk("tt_pos_cnt", t_pos_cnt, tbl[i].pc);
      chk("tt_neg_cnt", t_neg_cnt, tbl[i].nc);
      t_ready = 1'b1;
      @(negedge clk);
      t_ready = 1'b0;
      chk("tt_out_valid_clr", t_out_valid, 0);
      chk("tt_in_ready_back", t_in_ready, 1);
    end

    send_beat(8'hFF, 8'hF0);
    send_beat(8'h00, 8'hF0);
    send_beat(8'h0F, 8'hF0);
    chk("s2_not_yet_valid", out_valid, 0);
    send_beat(8'h01, 8'hF0);
    chk("s2_out_valid", out_valid, 1);
    chk("s2_pos_cnt", pos_cnt, 13);
    chk("s2_neg_cnt", neg_cnt, 16);
    chk("s2_outval", outval, 0);
    chk("s2_bias3_outval", b_outval, 1);

    in_valid = 1'b1;
    pos = 8'hFF;
    neg = 8'h00;
    repeat (5) begin
      @(negedge clk);
      chk("s3_out_valid", out_valid, 1);
      chk("s3_in_ready", in_ready, 0);
      chk("s3_pos_cnt", pos_cnt, 13);
      chk("s3_neg_cnt", neg_cnt, 16);
      chk("s3_outval", outval, 0);
    end
    in_valid = 1'b0;
    release_decision();
    chk("s3_out_valid_clr", out_valid, 0);
    chk("s3_in_ready_back", in_ready, 1);

    send_beat(8'hFF, 8'h00);
    send_beat(8'hFF, 8'h00);
    clear = 1'b1;
    in_valid = 1'b1;
    pos = 8'hFF;
    neg = 8'hFF;
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    chk("s4_clr_out_valid", out_valid, 0);
    chk("s4_clr_keeps_cnt", pos_cnt, 13);
    repeat (3) send_beat(8'hFF, 8'h00);
    chk("s4_no_early_valid", out_valid, 0);
    send_beat(8'hFF, 8'h00);
    chk("s4_out_valid", out_valid, 1);
    chk("s4_pos_cnt", pos_cnt, 32);
    chk("s4_neg_cnt", neg_cnt, 0);
    chk("s4_outval", outval, 1);
    release_decision();

    repeat (3) send_beat(8'hFF, 8'hFF);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_rst_in_ready", in_ready, 1);
    chk("s5_rst_out_valid", out_valid, 0);
    chk("s5_rst_pos_cnt", pos_cnt, 0);
    chk("s5_rst_neg_cnt", neg_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    repeat (4) send_beat(8'h01, 8'h03);
    chk("s5a_pos_cnt", pos_cnt, 4);
    chk("s5a_neg_cnt", neg_cnt, 8);
    chk("s5a_outval", outval, 0);
    chk("s5a_bias3_outval", b_outval, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_hold_rst_out_valid", out_valid, 0);
    chk("s5_hold_rst_pos_cnt", pos_cnt, 0);
    chk("s5_hold_rst_outval", outval, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    repeat (4) send_beat(8'h0F, 8'h01);
    chk("s5b_pos_cnt", pos_cnt, 16);
    chk("s5b_neg_cnt", neg_cnt, 4);
    chk("s5b_outval", outval, 1);
    release_decision();

    // Random streaming; the model tracks one outstanding decision as a queue entry.
    m_pacc = 0;
    m_nacc = 0;
    m_beats = 0;
    done = 0;
    cyc = 0;
    while (done < 4000 && cyc < 60000) begin
      cyc++;
      chk("rnd_out_valid", out_valid, exp_q.size() != 0);
      chk("rnd_in_ready", in_ready, exp_q.size() == 0);
      if (exp_q.size() != 0) begin
        chk("rnd_pos_cnt", pos_cnt, exp_q[0].p);
        chk("rnd_neg_cnt", neg_cnt, exp_q[0].n);
        chk("rnd_outval", outval, exp_q[0].o);
        chk("rnd_bias3_outval", b_outval, exp_q[0].ob);
      end
      in_valid  = ($urandom_range(0, 7) != 0);
      pos       = 8'($urandom);
      neg       = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 99) == 0);
      if (clear) begin
        m_pacc = 0;
        m_nacc = 0;
        m_beats = 0;
        exp_q.delete();
      end else if (exp_q.size() == 0) begin
        if (in_valid) begin
          m_pacc += $countones(pos);
          m_nacc += $countones(neg);
          m_beats++;
          if (m_beats == 4) begin
            d.p  = m_pacc;
            d.n  = m_nacc;
            d.o  = (m_pacc >= m_nacc);
            d.ob = (m_pacc + 3 >= m_nacc);
            exp_q.push_back(d);
            m_pacc = 0;
            m_nacc = 0;
            m_beats = 0;
          end
        end
      end else if (out_ready) begin
        void'(exp_q.pop_front());
        done++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    clear = 1'b0;
    chk("rnd_samples_done", done, 4000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
